// File: rtl/ifetch_defs_pkg.sv
// Shared fetch definitions: opcode field layout, jump opcode and default reset PC.
package ifetch_defs;

  localparam int         OPC_W            = 6;
  localparam logic [5:0] OPC_JUMP         = 6'b000010;
  localparam int         RESET_PC_DEFAULT = 0;

  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return opc == OPC_JUMP;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue storage: DEPTH entries of {inst, pc}, flush beats push/pop.
module ifetch_fifo #(
  parameter int  WIDTH = 48,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign do_push   = push && !flush;
  assign do_pop    = pop && (count_reg != '0);
  assign head_data = mem[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

  // Storage carries no reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction fetch PC generator with prefetch queue, redirect flush and jump predecode.
// Optional IFETCH_PERF_EN adds fetch/flush/stall performance counters.
module ifetch_prefetch_queue
  import ifetch_defs::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = INST_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]     outstanding_reg, outstanding_next;
  logic [CW-1:0]     drop_reg, drop_next;

  logic [EW-1:0]     head_entry;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;
  logic              q_empty;
  logic [CW-1:0]     q_count;

  logic              pop, jump_pop, redirect, credit_ok, req_fire, push;
  logic [ADDR_W-1:0] redirect_pc;

  ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc_reg}),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign head_inst  = head_entry[EW-1 -: INST_W];
  assign head_pc    = head_entry[ADDR_W-1:0];
  assign inst_valid = !q_empty;
  assign inst_data  = inst_valid ? head_inst : '0;
  assign inst_pc    = inst_valid ? head_pc : '0;

  assign pop         = inst_valid && inst_ready;
  assign jump_pop    = pop && is_jump(head_inst[INST_W-1 -: OPC_W]);
  assign redirect    = redir_valid || jump_pop;
  assign redirect_pc = redir_valid ? redir_pc : head_inst[ADDR_W-1:0];

  // Queue slots plus in-flight fetches never exceed DEPTH, so a response always has room.
  assign credit_ok      = ({1'b0, q_count} + {1'b0, outstanding_reg}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = !rst && !redir_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_reg == '0) && !redirect;

  always_comb begin
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    drop_next        = drop_reg;
    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_next = redirect_pc;
      rsp_pc_next   = redirect_pc;
      drop_next     = outstanding_next;
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
      if (push)     rsp_pc_next   = rsp_pc_reg + ADDR_W'(1);
      if (imem_rsp_valid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_fire)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect)                 perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (inst_valid && !inst_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for ifetch_prefetch_queue with an in-order, variable-latency memory model.
module tb_ifetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_mism = 0;
  int cyc = 0;
  int lat = 1;
  int acc_cnt = 0;
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] acc_log[$];
  logic [15:0] pop_pc[$];
  logic [31:0] pop_data[$];

  ifetch_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0042) return 32'h0800_0123;
    return {6'b000001, 10'h155, a};
  endfunction

  // Memory: capture accepted requests at the edge, present responses 1 ns later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat - 1);
      acc_log.push_back(imem_req_addr);
      acc_cnt++;
    end
    if (!rst && inst_valid && inst_ready) begin
      pop_pc.push_back(inst_pc);
      pop_data.push_back(inst_data);
      $display("pop  pc=%h data=%h", inst_pc, inst_data);
    end
    #1;
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_pc.delete();
    pop_data.delete();
    acc_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    clear_logs();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(1);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr",  32'(imem_req_addr), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc",   32'(inst_pc), 32'h0);

    // 1: streaming fetch, 1-cycle memory, decode always ready
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    tick(8);
    check("t1_pop_count", pop_pc.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_pc%0d", i), 32'(pop_pc[i]), i);
      check($sformatf("t1_data%0d", i), pop_data[i], {6'b000001, 10'h155, 16'(i)});
    end

    // 2: decode stalled from reset -> exactly DEPTH requests, nothing lost
    inst_ready = 1'b0;
    do_reset();
    tick(20);
    check("t2_acc_count", acc_cnt, 32'd4);
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_inst_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", 32'(inst_pc), 32'h0);
    check("t2_no_pop", pop_pc.size(), 32'd0);
    inst_ready = 1'b1;
    tick(6);
    check("t2_pop_count", pop_pc.size(), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("t2_pc%0d", i), 32'(pop_pc[i]), i);

    // 3+4: redirect with 3 fetches in flight, then a jump at 0x0042 to 0x0123
    lat = 10;
    do_reset();
    tick(3);
    imem_req_ready = 1'b0;
    redir_valid = 1'b1; redir_pc = 16'h0040;
    #1 check("t3_req_held_low", 32'(imem_req_valid), 32'd0);
    check("t3_inflight", acc_cnt, 32'd3);
    tick(1);
    redir_valid = 1'b0;
    check("t3_fetch_addr", 32'(imem_req_addr), 32'h0040);
    imem_req_ready = 1'b1;
    tick(100);
    check("t3_pop_count_ge5", 32'(pop_pc.size() >= 5), 32'd1);
    check("t3_pc0", 32'(pop_pc[0]), 32'h0040);
    check("t3_data0", pop_data[0], 32'h0555_0040);
    check("t3_pc1", 32'(pop_pc[1]), 32'h0041);
    check("t4_jump_pc", 32'(pop_pc[2]), 32'h0042);
    check("t4_jump_data", pop_data[2], 32'h0800_0123);
    check("t4_target_pc", 32'(pop_pc[3]), 32'h0123);
    check("t4_target_data", pop_data[3], 32'h0555_0123);
    check("t4_next_pc", 32'(pop_pc[4]), 32'h0124);

    // 5: fetch address wraps at 0xFFFF
    lat = 1;
    redir_valid = 1'b1; redir_pc = 16'hFFFE;
    tick(1);
    redir_valid = 1'b0;
    clear_logs();
    tick(30);
    check("t5_acc_count_ge4", 32'(acc_log.size() >= 4), 32'd1);
    check("t5_acc0", 32'(acc_log[0]), 32'hFFFE);
    check("t5_acc1", 32'(acc_log[1]), 32'hFFFF);
    check("t5_acc2_wrap", 32'(acc_log[2]), 32'h0000);
    check("t5_acc3", 32'(acc_log[3]), 32'h0001);
    check("t5_pop0", 32'(pop_pc[0]), 32'hFFFE);
    check("t5_pop1", 32'(pop_pc[1]), 32'hFFFF);
    check("t5_pop2_wrap", 32'(pop_pc[2]), 32'h0000);
    check("t5_pop2_data", pop_data[2], 32'h0555_0000);

    // 6: reset with a full queue
    inst_ready = 1'b0;
    tick(10);
    check("t6_full_valid", 32'(inst_valid), 32'd1);
    check("t6_full_req_low", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    #1 check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    tick(2);
    clear_logs();
    rst = 1'b0;
    #1 check("t6_rel_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rel_req_addr", 32'(imem_req_addr), 32'h0);
    check("t6_rel_req_valid", 32'(imem_req_valid), 32'd1);
    inst_ready = 1'b1;
    tick(4);
    check("t6_pop_count_ge1", 32'(pop_pc.size() >= 1), 32'd1);
    check("t6_first_pc", 32'(pop_pc[0]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
